fpu_norm_sched: RTL

//  Shares one leading-one-detect and normalize datapath among NUM_REQ FPU producers
//  (e.g. mul and add mantissa lanes).

---
 rtl/fpu_norm_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_norm_sched.sv
// Shared leading-one detect / normalize unit: round-robin arbiter feeding a two-stage pipeline.
// Optional per-requester grant counters are enabled with `define FPU_NORM_PERF_EN.
`timescale 1ns/1ps

module fpu_norm_sched #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned ID_W      = 1,
   parameter int unsigned WIDTH     = 106,
   parameter int unsigned WIDTH_LOG = 7,
   parameter int unsigned TAG_W     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_value,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_value,
   output logic [WIDTH_LOG:0]       out_msb,
   output logic                     out_zero,
   output logic [TAG_W-1:0]         out_tag,
   output logic [ID_W-1:0]          out_id,
   output logic [NUM_REQ*16-1:0]    perf_cnt
);

   localparam int unsigned MSB_W  = WIDTH_LOG + 1;
   localparam int unsigned PERF_W = 16;

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_value_q, s1_value_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic [ID_W-1:0]  s1_id_q, s1_id_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_value_q, out_value_d;
   logic [MSB_W-1:0] out_msb_q, out_msb_d;
   logic             out_zero_q, out_zero_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic [ID_W-1:0]  out_id_q, out_id_d;

   logic             s2_adv_c, s1_adv_c, can_acc_c, accept_c;
   logic             found_c;
   logic [ID_W-1:0]  grant_c, cand_c;
   logic [WIDTH-1:0] acc_value_c;
   logic [TAG_W-1:0] acc_tag_c;
   logic [MSB_W-1:0] msb_c, shamt_c;
   logic             zero_c;
   logic [WIDTH-1:0] norm_c;

   assign s2_adv_c  = !out_valid_q || out_ready;
   assign s1_adv_c  = s1_valid_q && s2_adv_c;
   assign can_acc_c = !s1_valid_q || s2_adv_c;
   assign accept_c  = found_c && can_acc_c;

   // Round-robin scan starting at rr_ptr; first valid requester wins.
   always_comb begin
      grant_c     = '0;
      found_c     = 1'b0;
      cand_c      = '0;
      acc_value_c = '0;
      acc_tag_c   = '0;
      req_ready   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand_c = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!found_c && req_valid[cand_c]) begin
            grant_c = cand_c;
            found_c = 1'b1;
         end
      end
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         if (grant_c == ID_W'(r)) begin
            acc_value_c = req_value[r*WIDTH +: WIDTH];
            acc_tag_c   = req_tag[r*TAG_W +: TAG_W];
            req_ready[r] = can_acc_c && found_c;
         end
      end
   end

   // Leading-one detect and left-justify of the S1 value.
   always_comb begin
      msb_c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (s1_value_q[i]) msb_c = MSB_W'(i);
      end
      zero_c  = (s1_value_q == '0);
      shamt_c = MSB_W'(WIDTH - 1) - msb_c;
      norm_c  = s1_value_q << shamt_c;
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      s1_valid_d  = s1_valid_q;
      s1_value_d  = s1_value_q;
      s1_tag_d    = s1_tag_q;
      s1_id_d     = s1_id_q;
      out_valid_d = out_valid_q;
      out_value_d = out_value_q;
      out_msb_d   = out_msb_q;
      out_zero_d  = out_zero_q;
      out_tag_d   = out_tag_q;
      out_id_d    = out_id_q;

      if (s2_adv_c) out_valid_d = s1_valid_q;
      if (s1_adv_c) begin
         out_value_d = norm_c;
         out_msb_d   = msb_c;
         out_zero_d  = zero_c;
         out_tag_d   = s1_tag_q;
         out_id_d    = s1_id_q;
         s1_valid_d  = 1'b0;
      end
      if (accept_c) begin
         s1_valid_d = 1'b1;
         s1_value_d = acc_value_c;
         s1_tag_d   = acc_tag_c;
         s1_id_d    = grant_c;
         rr_ptr_d   = (grant_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_c + ID_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_value_q  <= '0;
         s1_tag_q    <= '0;
         s1_id_q     <= '0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_msb_q   <= '0;
         out_zero_q  <= 1'b0;
         out_tag_q   <= '0;
         out_id_q    <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_value_q  <= s1_value_d;
         s1_tag_q    <= s1_tag_d;
         s1_id_q     <= s1_id_d;
         out_valid_q <= out_valid_d;
         out_value_q <= out_value_d;
         out_msb_q   <= out_msb_d;
         out_zero_q  <= out_zero_d;
         out_tag_q   <= out_tag_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_value = out_value_q;
   assign out_msb   = out_msb_q;
   assign out_zero  = out_zero_q;
   assign out_tag   = out_tag_q;
   assign out_id    = out_id_q;

`ifdef FPU_NORM_PERF_EN
   logic [PERF_W-1:0] perf_q [NUM_REQ];
   logic [PERF_W-1:0] perf_d [NUM_REQ];

   // Saturating accept counters, one per requester.
   always_comb begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         perf_d[r] = perf_q[r];
         if (accept_c && (grant_c == ID_W'(r)) && (perf_q[r] != {PERF_W{1'b1}}))
            perf_d[r] = perf_q[r] + PERF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         if (rst) perf_q[r] <= '0;
         else     perf_q[r] <= perf_d[r];
      end
   end

   always_comb begin
      perf_cnt = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) perf_cnt[r*PERF_W +: PERF_W] = perf_q[r];
   end
`else
   assign perf_cnt = '0;
`endif

endmodule
